// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers for the round-robin arbiter family.
package arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_e;

   // Wraps explicitly at n, so any requester count works (not only powers of two).
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_if #(
   parameter int N = 8,
   parameter int W = $clog2(N)
);
   logic [N-1:0] req;
   logic [N-1:0] lock;
   logic [N-1:0] gnt;
   logic [W-1:0] gnt_id;
   logic         gnt_vld;

   modport master (output req, output lock, input gnt, input gnt_id, input gnt_vld);
   modport slave  (input req, input lock, output gnt, output gnt_id, output gnt_vld);
endinterface

// File: rtl/rr_arbiter_prio_enc.sv
// LSB-first fixed-priority encoder: one-hot, index and valid of the lowest set bit.
module prio_enc #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] in,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx,
   output logic         vld
);

   assign onehot = in & (~in + N'(1));
   assign vld    = |in;

   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (in[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered grant and lock, bounded by MAX_HOLD.
//   state | meaning
//   IDLE  | no grant outstanding, gnt_vld = 0
//   OWNED | gnt_id owns the resource, gnt_vld = 1
module rr_arbiter
   import arb_pkg::*;
#(
   parameter  int N        = 8,
   parameter  int MAX_HOLD = 16,
   localparam int W        = $clog2(N),
   localparam int HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
   input logic          clk,
   input logic          rst,
   rr_arbiter_if.slave  bus
);

   localparam logic [0:0] ST_IDLE  = 1'(ARB_IDLE);
   localparam logic [0:0] ST_OWNED = 1'(ARB_OWNED);
   localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

   logic [0:0]    state;
   logic [W-1:0]  ptr;
   logic [HW-1:0] hold_cnt;
   logic [N-1:0]  gnt_q;
   logic [W-1:0]  gnt_id_q;

   logic [N-1:0]  mask;
   logic [N-1:0]  m_oh, u_oh, win_oh;
   logic [W-1:0]  m_id, u_id, win_id;
   logic          m_vld, u_vld, win_vld;
   logic          lim_hit, keep;

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) mask[i] = (i >= int'(ptr));
   end

   prio_enc #(.N(N), .W(W)) u_masked (
      .in     (bus.req & mask),
      .onehot (m_oh),
      .idx    (m_id),
      .vld    (m_vld)
   );

   prio_enc #(.N(N), .W(W)) u_plain (
      .in     (bus.req),
      .onehot (u_oh),
      .idx    (u_id),
      .vld    (u_vld)
   );

   assign win_oh  = m_vld ? m_oh : u_oh;
   assign win_id  = m_vld ? m_id : u_id;
   assign win_vld = m_vld | u_vld;

   // Lock is honoured only for the current owner and only while it still requests.
   assign lim_hit = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);
   assign keep    = (state == ST_OWNED) && bus.req[gnt_id_q] && bus.lock[gnt_id_q] && !lim_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
      end else if (keep) begin
         hold_cnt <= hold_cnt + HW'(1);
      end else if (win_vld) begin
         state    <= ST_OWNED;
         gnt_q    <= win_oh;
         gnt_id_q <= win_id;
         ptr      <= W'(rr_next(32'(win_id), N));
         hold_cnt <= '0;
      end else begin
         state    <= ST_IDLE;
         gnt_q    <= '0;
         hold_cnt <= '0;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_id  = gnt_id_q;
   assign bus.gnt_vld = (state == ST_OWNED);

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed checks of rr_arbiter (N=8, MAX_HOLD=4) against hand-computed grants.
module tb_rr_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   rr_arbiter_if #(.N(8)) bus ();

   rr_arbiter #(.N(8), .MAX_HOLD(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_gnt(input string tag, input logic [7:0] exp_gnt, input logic [2:0] exp_id);
      chk({tag, ".gnt"}, 32'(bus.gnt), 32'(exp_gnt));
      chk({tag, ".vld"}, 32'(bus.gnt_vld), 32'(exp_gnt != 8'h00));
      if (exp_gnt != 8'h00) chk({tag, ".id"}, 32'(bus.gnt_id), 32'(exp_id));
   endtask

   task automatic do_reset(input logic [7:0] r, input logic [7:0] l);
      rst      = 1'b1;
      bus.req  = r;
      bus.lock = l;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.req  = 8'hFF;
      bus.lock = 8'h00;

      // reset state with all requests high
      tick();
      tick();
      chk("rst.gnt", 32'(bus.gnt), 32'h0);
      chk("rst.vld", 32'(bus.gnt_vld), 32'h0);
      chk("rst.id", 32'(bus.gnt_id), 32'h0);
      chk("rst.ptr", 32'(dut.ptr), 32'h0);
      chk("rst.hold", 32'(dut.hold_cnt), 32'h0);

      // full rotation 0..7 then wrap to 0
      rst = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         tick();
         chk_gnt($sformatf("rot%0d", i), 8'h01 << (i % 8), 3'(i % 8));
      end

      // sparse requests alternate
      do_reset(8'h24, 8'h00);
      tick(); chk_gnt("alt0", 8'h04, 3'd2);
      tick(); chk_gnt("alt1", 8'h20, 3'd5);
      tick(); chk_gnt("alt2", 8'h04, 3'd2);

      // hold limit with competing requesters
      do_reset(8'h08, 8'h00);
      tick(); chk_gnt("hold0", 8'h08, 3'd3);
      bus.req  = 8'hFF;
      bus.lock = 8'h08;
      tick(); chk_gnt("hold1", 8'h08, 3'd3);
      tick(); chk_gnt("hold2", 8'h08, 3'd3);
      tick(); chk_gnt("hold3", 8'h08, 3'd3);
      chk("hold3.cnt", 32'(dut.hold_cnt), 32'd3);
      tick(); chk_gnt("hold4", 8'h10, 3'd4);
      chk("hold4.cnt", 32'(dut.hold_cnt), 32'd0);

      // sole locked requester re-wins, counter wraps every 4 cycles
      do_reset(8'h08, 8'h08);
      for (int t = 1; t <= 9; t++) begin
         tick();
         chk_gnt($sformatf("solo%0d", t), 8'h08, 3'd3);
         chk($sformatf("solo%0d.cnt", t), 32'(dut.hold_cnt), 32'((t - 1) % 4));
      end

      // owner drops req with lock still high: released, search from 6
      do_reset(8'h20, 8'h20);
      tick(); chk_gnt("drop0", 8'h20, 3'd5);
      tick(); chk_gnt("drop1", 8'h20, 3'd5);
      bus.req = 8'h81;
      tick(); chk_gnt("drop2", 8'h80, 3'd7);
      tick(); chk_gnt("drop3", 8'h01, 3'd0);
      bus.req = 8'h00;
      tick(); chk_gnt("drop4", 8'h00, 3'd0);
      chk("drop4.ptr", 32'(dut.ptr), 32'd1);

      // reset mid-lock
      do_reset(8'h40, 8'h40);
      tick(); chk_gnt("rlk0", 8'h40, 3'd6);
      tick(); chk_gnt("rlk1", 8'h40, 3'd6);
      rst     = 1'b1;
      bus.req = 8'hC1;
      tick();
      chk_gnt("rlk2", 8'h00, 3'd0);
      chk("rlk2.ptr", 32'(dut.ptr), 32'd0);
      rst = 1'b0;
      tick(); chk_gnt("rlk3", 8'h01, 3'd0);
      tick(); chk_gnt("rlk4", 8'h40, 3'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised round-robin arbiter with registered one-hot grant, encoded grant index and optional grant locking with a bounded hold time. It succeeds the fixed-priority arbiter and priority encoder. It sits between N bus or shared-resource requesters and the resource mux, and drives the mux select directly from `gnt_id`.

## Interface
- `N`, 8: number of requesters, at least 2.
- `W`, `$clog2(N)`: grant index width, derived.
- `MAX_HOLD`, 16: maximum consecutive cycles one owner may keep a locked grant. 0 disables the limit.

Ports:
- `clk` in 1: the single clock. Everything is sampled on the rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `req` in N: request vector, bit i is requester i.
- `lock` in N: requester i asks to keep its current grant. Only meaningful while i owns the grant and `req[i]` is high.
- `gnt` out N: registered one-hot grant, or all zeros.
- `gnt_id` out W: index of the granted requester. Valid only while `gnt_vld` is high.
- `gnt_vld` out 1: high when `gnt` is non-zero.

## Operation
- State:
  - `ptr` (W bits): the highest-priority index for the next arbitration.
  - `gnt`/`gnt_id`/`gnt_vld` registers.
  - `hold_cnt`, width `$clog2(MAX_HOLD+1)`.
- Ownership FSM, two states:
  - IDLE: `gnt_vld` is 0.
  - OWNED: `gnt_vld` is 1, owner is `gnt_id`.
- Keep rule, applied each cycle in OWNED with owner o:
  - If `req[o] & lock[o]` and the hold limit is not reached, the grant is unchanged.
  - Otherwise the arbiter performs a new arbitration.
- New arbitration:
  - Pick the first set bit of `req` searching upward from `ptr` with wrap-around, modulo N.
  - If one is found:
    - Register its one-hot grant and index.
    - Set `ptr` to winner+1 modulo N. The wrap N-1 goes to 0.
    - Clear `hold_cnt`.
    - Enter OWNED.
  - If `req` is all zeros:
    - `gnt` = 0 and `gnt_vld` = 0.
    - `ptr` is unchanged.
    - Enter IDLE.
- Hold limit, applies only when `MAX_HOLD` > 0:
  - `hold_cnt` increments on every cycle the grant is kept by lock.
  - When `hold_cnt` equals `MAX_HOLD`-1 and lock is still asserted, the lock is ignored for that evaluation and a new arbitration runs.
  - Because `ptr` is already owner+1, the other requesters win first.
  - If the owner is the only requester, it re-wins and `hold_cnt` restarts at 0.
- An unlocked grant lasts exactly one cycle, then re-arbitration runs. With all N requests held high and no lock, the grant rotates 0,1,…,N-1,0.
- Changes to `req` or `lock` on a non-owner have no effect on a kept grant.
- If the owner drops `req` while `lock` is high, the lock is released. `lock` alone never keeps a grant.

## Timing
- Reset values: `gnt` = 0, `gnt_id` = 0, `gnt_vld` = 0, `ptr` = 0, `hold_cnt` = 0.
  - After reset, requester 0 has the highest priority.
- Latency: `req` sampled at edge k gives `gnt` visible after edge k. Registered, one cycle.
- Release latency: owner drops `req` at edge k, so from edge k `gnt` moves to the next requester, or goes to 0.
- Worst-case wait for a requester holding `req` high:
  - `MAX_HOLD` > 0: at most (N-1)·`MAX_HOLD` cycles.
  - `MAX_HOLD` = 0 with permanent lock: unbounded, which is accepted.
- `rst` asserted mid-lock: outputs and `ptr` return to reset values at that edge, regardless of `req`/`lock`.
- Outputs are pure registers. There is no combinational path from inputs to outputs.

## Structure
- The shared package `arb_pkg` holds:
  - the IDLE/OWNED state enum;
  - the function `rr_next(ptr)`, which returns (ptr+1) mod N without the power-of-two assumption.
- Sub-module `prio_enc`: parametrised LSB-first fixed-priority encoder (N-bit input; one-hot, index and valid outputs).
- `rr_arbiter` instantiates `prio_enc` twice:
  - one on `req` masked to bits ≥ `ptr`;
  - one on the unmasked `req`;
  - the masked result wins if its valid is set.
- Target size is about 150–250 lines of RTL in total.

## Test plan
- Reset with `req`=8'hFF and `lock`=0: after reset `gnt` = 01, then 02, 04 … 80, 01; `gnt_id` counts 0..7 and wraps.
- `req`=8'h24, `lock`=0, `ptr`=0: `gnt` alternates 04, 20, 04.
- `req`=8'hFF with `lock[3]` held and `MAX_HOLD`=4, starting from a grant to 3: `gnt`=08 for exactly 4 cycles, then 10; `hold_cnt` resets.
- `MAX_HOLD`=4 with `req`=8'h08 and `lock`=8'h08: `gnt` stays 08 continuously and `hold_cnt` wraps every 4 cycles; `gnt_vld` never drops.
- Owner 5 locked, then `req[5]` drops with `req`=8'h81 and `lock[5]` still high: the next `gnt` is 80 (search starts at 6), then 01.
- `rst` pulsed while owner 6 is locked: at the next edge `gnt`=0, `gnt_vld`=0, `ptr`=0; with `req`=8'hC1, the first grant after reset is 01.
